// File: rtl/mem_access_stage.sv
// MEM stage of a 5-stage MIPS pipeline: EX/MEM register, branch resolve, req/ack data memory
// access with upstream stall, and registered MEM/WB bundle. Optional ack timeout: MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ex_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_branch,
  input  logic              i_mem_to_reg,
  input  logic              i_reg_write,
  input  logic [DATA_W-1:0] i_alu_res,
  input  logic              i_alu_zero,
  input  logic [DATA_W-1:0] i_pc_branch,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [4:0]        i_write_reg,
  output logic              o_stall,
  output logic              o_pc_src,
  output logic [DATA_W-1:0] o_pc_target,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_reg_write,
  output logic              o_wb_mem_to_reg,
  output logic [DATA_W-1:0] o_wb_read_data,
  output logic [DATA_W-1:0] o_wb_alu_res,
  output logic [4:0]        o_wb_write_reg,
  output logic              o_mem_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

  state_t r_state, w_state_d;

  // EX/MEM slot
  logic              r_valid, r_mem_read, r_mem_write, r_branch, r_mem_to_reg, r_reg_write;
  logic              r_alu_zero;
  logic [DATA_W-1:0] r_alu_res, r_pc_branch, r_rt_data;
  logic [4:0]        r_write_reg;

  // MEM/WB bundle
  logic              r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg, r_mem_err;
  logic [DATA_W-1:0] r_wb_read_data, r_wb_alu_res;
  logic [4:0]        r_wb_write_reg;

  logic w_is_mem, w_misaligned, w_stall, w_wb_direct, w_acc_done, w_tmo_hit;

  assign w_is_mem     = r_valid & (r_mem_read | r_mem_write);
  assign w_misaligned = (r_alu_res[1:0] != 2'b00);
  assign w_stall      = ((r_state == StIdle) && w_is_mem && !w_misaligned) ||
                        (r_state == StAccess);
  assign w_wb_direct  = (r_state == StIdle) && r_valid && !w_stall;
  assign w_acc_done   = (r_state == StAccess) && (i_dmem_ack || w_tmo_hit);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TmoW-1:0] r_tmo_cnt;

  // Counts ACCESS cycles from zero; fires on the TIMEOUT-th cycle without ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StAccess) begin
      r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_hit = (r_state == StAccess) && (r_tmo_cnt == TmoW'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_is_mem && !w_misaligned) w_state_d = StAccess;
      StAccess: if (w_acc_done) w_state_d = StResp;
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid         <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_branch        <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_reg_write     <= 1'b0;
      r_alu_zero      <= 1'b0;
      r_alu_res       <= '0;
      r_pc_branch     <= '0;
      r_rt_data       <= '0;
      r_write_reg     <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_mem_err       <= 1'b0;
      r_wb_read_data  <= '0;
      r_wb_alu_res    <= '0;
      r_wb_write_reg  <= '0;
    end else begin
      if (!w_stall) begin
        r_valid <= i_ex_valid;
        if (i_ex_valid) begin
          r_mem_read   <= i_mem_read;
          r_mem_write  <= i_mem_write;
          r_branch     <= i_branch;
          r_mem_to_reg <= i_mem_to_reg;
          r_reg_write  <= i_reg_write;
          r_alu_zero   <= i_alu_zero;
          r_alu_res    <= i_alu_res;
          r_pc_branch  <= i_pc_branch;
          r_rt_data    <= i_rt_data;
          r_write_reg  <= i_write_reg;
        end
      end

      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_mem_err      <= 1'b0;
      // Non-memory op, or misaligned access that never reaches the memory port.
      if (w_wb_direct) begin
        r_wb_valid      <= 1'b1;
        r_wb_reg_write  <= r_reg_write & ~w_is_mem;
        r_mem_err       <= w_is_mem;
        r_wb_mem_to_reg <= r_mem_to_reg;
        r_wb_alu_res    <= r_alu_res;
        r_wb_write_reg  <= r_write_reg;
      end else if (w_acc_done) begin
        r_wb_valid      <= 1'b1;
        r_wb_reg_write  <= r_reg_write & ~r_mem_write & i_dmem_ack;
        r_mem_err       <= ~i_dmem_ack;
        r_wb_mem_to_reg <= r_mem_to_reg;
        r_wb_alu_res    <= r_alu_res;
        r_wb_write_reg  <= r_write_reg;
        if (i_dmem_ack && !r_mem_write) begin
          r_wb_read_data <= i_dmem_rdata;
        end
      end
    end
  end

  assign o_stall         = w_stall;
  assign o_pc_src        = r_valid & r_branch & r_alu_zero;
  assign o_pc_target     = r_pc_branch;
  assign o_dmem_req      = (r_state == StAccess);
  assign o_dmem_we       = o_dmem_req & r_mem_write;
  assign o_dmem_addr     = o_dmem_req ? r_alu_res : '0;
  assign o_dmem_wdata    = o_dmem_req ? r_rt_data : '0;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_reg_write  = r_wb_reg_write;
  assign o_wb_mem_to_reg = r_wb_mem_to_reg;
  assign o_wb_read_data  = r_wb_read_data;
  assign o_wb_alu_res    = r_wb_alu_res;
  assign o_wb_write_reg  = r_wb_write_reg;
  assign o_mem_err       = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; timeout scenario under MEM_TIMEOUT_EN.
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic        ex_valid, mem_read, mem_write, branch, mem_to_reg, reg_write, alu_zero;
  logic [31:0] alu_res, pc_branch, rt_data;
  logic [4:0]  write_reg;
  logic        stall, pc_src, dmem_req, dmem_we, dmem_ack;
  logic [31:0] pc_target, dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, mem_err;
  logic [31:0] wb_read_data, wb_alu_res;
  logic [4:0]  wb_write_reg;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.DATA_W(32), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_branch(branch), .i_mem_to_reg(mem_to_reg),
    .i_reg_write(reg_write), .i_alu_res(alu_res), .i_alu_zero(alu_zero),
    .i_pc_branch(pc_branch), .i_rt_data(rt_data), .i_write_reg(write_reg),
    .o_stall(stall), .o_pc_src(pc_src), .o_pc_target(pc_target), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata), .o_wb_valid(wb_valid),
    .o_wb_reg_write(wb_reg_write), .o_wb_mem_to_reg(wb_mem_to_reg),
    .o_wb_read_data(wb_read_data), .o_wb_alu_res(wb_alu_res), .o_wb_write_reg(wb_write_reg),
    .o_mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rd, input logic wr, input logic br,
                          input logic m2r, input logic rw, input logic [31:0] alu,
                          input logic zero, input logic [31:0] pcb, input logic [31:0] rt,
                          input logic [4:0] wreg);
    ex_valid = v; mem_read = rd; mem_write = wr; branch = br; mem_to_reg = m2r;
    reg_write = rw; alu_res = alu; alu_zero = zero; pc_branch = pcb; rt_data = rt;
    write_reg = wreg;
  endtask

  // Plays the memory side: acks on the ack_after-th request cycle (0 = never).
  // Returns just after the edge that leaves ACCESS, or with timed_out=1 after 100 cycles.
  task automatic run_access(input int ack_after, input logic [31:0] rdata,
                            output int req_cycles, output logic [31:0] first_addr,
                            output logic first_we, output logic [31:0] first_wdata,
                            output logic stall_ok, output logic timed_out);
    req_cycles = 0; first_addr = '0; first_we = 1'b0; first_wdata = '0;
    stall_ok = 1'b1; timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (dmem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          first_addr = dmem_addr; first_we = dmem_we; first_wdata = dmem_wdata;
        end
        if (!stall) stall_ok = 1'b0;
        if (ack_after != 0 && req_cycles == ack_after) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = 32'hBAD0BAD0;
        end
      end else if (req_cycles > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    dmem_ack = 1'b0; dmem_rdata = '0;
    step(); step();
    n_checks++;
    if ({stall, pc_src, pc_target, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid,
         wb_reg_write, wb_mem_to_reg, wb_read_data, wb_alu_res, wb_write_reg, mem_err} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got nonzero output, expected all zero");
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_op();
    logic stall_seen;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000002A, 1'b0, '0, '0, 5'd5);
    step();
    stall_seen = stall;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    step();
    stall_seen = stall_seen | stall;
    n_checks++;
    if ({wb_valid, wb_reg_write, wb_alu_res, wb_write_reg, stall_seen, dmem_req} !==
        {1'b1, 1'b1, 32'h2A, 5'd5, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL alu_op: got v=%b rw=%b alu=%h wr=%0d stall=%b req=%b, expected 1 1 2a 5 0 0",
               wb_valid, wb_reg_write, wb_alu_res, wb_write_reg, stall_seen, dmem_req);
    end
    step();
    n_checks++;
    if ({wb_valid, wb_reg_write} !== 2'b00) begin
      n_errors++; $display("FAIL empty_slot_wb: got v=%b rw=%b, expected 0 0", wb_valid, wb_reg_write);
    end
  endtask

  task automatic test_load();
    int n; logic [31:0] a, wd; logic we, sok, tmo;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, '0, '0, 5'd7);
    step();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    n_checks++;
    if ({stall, dmem_req} !== 2'b10) begin
      n_errors++; $display("FAIL load_stall_idle: got stall=%b req=%b, expected 1 0", stall, dmem_req);
    end
    run_access(3, 32'hDEADBEEF, n, a, we, wd, sok, tmo);
    n_checks++;
    if ({tmo, n, a, we, sok} !== {1'b0, 32'd3, 32'h100, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL load_access: got tmo=%b cycles=%0d addr=%h we=%b stall_ok=%b, expected 0 3 100 0 1",
               tmo, n, a, we, sok);
    end
    n_checks++;
    if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_read_data, wb_write_reg, stall, mem_err} !==
        {1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 5'd7, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL load_resp: got v=%b rw=%b m2r=%b rd=%h wr=%0d stall=%b err=%b, expected 1 1 1 deadbeef 7 0 0",
               wb_valid, wb_reg_write, wb_mem_to_reg, wb_read_data, wb_write_reg, stall, mem_err);
    end
  endtask

  task automatic test_store();
    int n; logic [31:0] a, wd; logic we, sok, tmo;
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, '0, 32'h12345678, 5'd9);
    step();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    run_access(1, 32'h0, n, a, we, wd, sok, tmo);
    n_checks++;
    if ({tmo, n, a, we, wd} !== {1'b0, 32'd1, 32'h200, 1'b1, 32'h12345678}) begin
      n_errors++;
      $display("FAIL store_access: got tmo=%b cycles=%0d addr=%h we=%b wdata=%h, expected 0 1 200 1 12345678",
               tmo, n, a, we, wd);
    end
    n_checks++;
    if ({wb_valid, wb_reg_write, wb_read_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL store_resp: got v=%b rw=%b rd=%h, expected 1 0 deadbeef",
               wb_valid, wb_reg_write, wb_read_data);
    end
    // read and write both set behaves as a store
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h204, 1'b0, '0, 32'hCAFEF00D, 5'd3);
    step();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    run_access(2, 32'h55555555, n, a, we, wd, sok, tmo);
    n_checks++;
    if ({n, we, wd, wb_valid, wb_reg_write, wb_read_data} !==
        {32'd2, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL rdwr_as_store: got cycles=%0d we=%b wdata=%h v=%b rw=%b rd=%h, expected 2 1 cafef00d 1 0 deadbeef",
               n, we, wd, wb_valid, wb_reg_write, wb_read_data);
    end
  endtask

  task automatic test_misaligned();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h103, 1'b0, '0, '0, 5'd4);
    step();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    n_checks++;
    if ({stall, dmem_req} !== 2'b00) begin
      n_errors++; $display("FAIL misaligned_nostall: got stall=%b req=%b, expected 0 0", stall, dmem_req);
    end
    step();
    n_checks++;
    if ({wb_valid, wb_reg_write, mem_err, dmem_req, wb_alu_res} !== {4'b1010, 32'h103}) begin
      n_errors++;
      $display("FAIL misaligned_wb: got v=%b rw=%b err=%b req=%b alu=%h, expected 1 0 1 0 103",
               wb_valid, wb_reg_write, mem_err, dmem_req, wb_alu_res);
    end
    step();
    n_checks++;
    if ({mem_err, dmem_req} !== 2'b00) begin
      n_errors++; $display("FAIL misaligned_pulse: got err=%b req=%b, expected 0 0", mem_err, dmem_req);
    end
  endtask

  task automatic test_branch();
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h40, '0, '0);
    step();
    n_checks++;
    if ({pc_src, pc_target} !== {1'b1, 32'h40}) begin
      n_errors++; $display("FAIL branch_taken: got src=%b tgt=%h, expected 1 40", pc_src, pc_target);
    end
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 32'h80, '0, '0);
    step();
    n_checks++;
    if ({pc_src, pc_target} !== {1'b0, 32'h80}) begin
      n_errors++; $display("FAIL branch_not_taken: got src=%b tgt=%h, expected 0 80", pc_src, pc_target);
    end
    drive_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hC0, '0, '0);
    step();
    n_checks++;
    if (pc_src !== 1'b0) begin
      n_errors++; $display("FAIL branch_empty_slot: got src=%b, expected 0", pc_src);
    end
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] a, wd; logic we, sok, tmo;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, '0, '0, 5'd1);
    step();
    // Second load waits on the inputs; ignored until the RESP cycle releases stall.
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b0, '0, '0, 5'd2);
    run_access(1, 32'h11111111, n, a, we, wd, sok, tmo);
    n_checks++;
    if ({n, a, wb_valid, wb_read_data, wb_write_reg, stall} !==
        {32'd1, 32'h10, 1'b1, 32'h11111111, 5'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_first: got cycles=%0d addr=%h v=%b rd=%h wr=%0d stall=%b, expected 1 10 1 11111111 1 0",
               n, a, wb_valid, wb_read_data, wb_write_reg, stall);
    end
    step();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    n_checks++;
    if ({stall, wb_valid} !== 2'b10) begin
      n_errors++; $display("FAIL b2b_capture: got stall=%b v=%b, expected 1 0", stall, wb_valid);
    end
    run_access(1, 32'h22222222, n, a, we, wd, sok, tmo);
    n_checks++;
    if ({n, a, wb_valid, wb_read_data, wb_write_reg, wb_alu_res} !==
        {32'd1, 32'h14, 1'b1, 32'h22222222, 5'd2, 32'h14}) begin
      n_errors++;
      $display("FAIL b2b_second: got cycles=%0d addr=%h v=%b rd=%h wr=%0d alu=%h, expected 1 14 1 22222222 2 14",
               n, a, wb_valid, wb_read_data, wb_write_reg, wb_alu_res);
    end
  endtask

  task automatic test_long_wait();
    int n; logic [31:0] a, wd; logic we, sok, tmo;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, '0, '0, 5'd11);
    step();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
`ifdef MEM_TIMEOUT_EN
    run_access(0, 32'h0, n, a, we, wd, sok, tmo);
    n_checks++;
    if ({tmo, n, sok} !== {1'b0, 32'd15, 1'b1}) begin
      n_errors++;
      $display("FAIL timeout_req_cycles: got tmo=%b cycles=%0d stall_ok=%b, expected 0 15 1", tmo, n, sok);
    end
    n_checks++;
    if ({wb_valid, wb_reg_write, mem_err, stall, dmem_req} !== 5'b10100) begin
      n_errors++;
      $display("FAIL timeout_resp: got v=%b rw=%b err=%b stall=%b req=%b, expected 1 0 1 0 0",
               wb_valid, wb_reg_write, mem_err, stall, dmem_req);
    end
`else
    run_access(20, 32'hA5A5A5A5, n, a, we, wd, sok, tmo);
    n_checks++;
    if ({tmo, n, sok} !== {1'b0, 32'd20, 1'b1}) begin
      n_errors++;
      $display("FAIL long_wait_cycles: got tmo=%b cycles=%0d stall_ok=%b, expected 0 20 1", tmo, n, sok);
    end
    n_checks++;
    if ({wb_valid, wb_reg_write, mem_err, wb_read_data} !== {3'b110, 32'hA5A5A5A5}) begin
      n_errors++;
      $display("FAIL long_wait_resp: got v=%b rw=%b err=%b rd=%h, expected 1 1 0 a5a5a5a5",
               wb_valid, wb_reg_write, mem_err, wb_read_data);
    end
`endif
    step();
    n_checks++;
    if ({mem_err, wb_valid} !== 2'b00) begin
      n_errors++; $display("FAIL long_wait_after: got err=%b v=%b, expected 0 0", mem_err, wb_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h44, '0, 5'd6);
    step();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    step();
    n_checks++;
    if ({dmem_req, dmem_addr} !== {1'b1, 32'h300}) begin
      n_errors++; $display("FAIL pre_reset_access: got req=%b addr=%h, expected 1 300", dmem_req, dmem_addr);
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if ({stall, pc_src, pc_target, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid,
         wb_reg_write, wb_mem_to_reg, wb_read_data, wb_alu_res, wb_write_reg, mem_err} !== '0) begin
      n_errors++;
      $display("FAIL mid_access_reset: got req=%b stall=%b v=%b rd=%h alu=%h, expected all zero",
               dmem_req, stall, wb_valid, wb_read_data, wb_alu_res);
    end
    step();
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFEEDFACE;
    step();
    dmem_ack = 1'b0;
    step();
    n_checks++;
    if ({wb_valid, dmem_req, stall, wb_read_data} !== {3'b000, 32'h0}) begin
      n_errors++;
      $display("FAIL late_ack_ignored: got v=%b req=%b stall=%b rd=%h, expected 0 0 0 0",
               wb_valid, dmem_req, stall, wb_read_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_misaligned();
    test_branch();
    test_back_to_back();
    test_long_wait();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
